wbuf_multi_fifo: RTL and testbench
==================================

WBUF_MULTI_FIFO -- requirements
Module: wbuf_multi_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of WID-tagged channels (2..8).
REQ-002 SHALL have parameter DEPTH, default 16, entries per channel (power of 2, >=2).
REQ-003 SHALL have parameter WIDTH, default 64, data beat width.
REQ-004 SHALL have parameter ID_W, default 11, WID/tag width.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_data  input  WIDTH  upstream write beat.
REQ-008 SHALL have port in_wid  input  ID_W  WID of the in_data beat.
REQ-009 SHALL have port in_valid  input  1  upstream beat valid.
REQ-010 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready.
REQ-011 SHALL have port flush  input  1  one-cycle pulse: burst for flush_wid is complete.
REQ-012 SHALL have port flush_wid  input  ID_W  WID being flushed.
REQ-013 SHALL have port flush_err  output  1  one-cycle pulse: flush named no allocated channel.
REQ-014 SHALL have port flush_done  output  1  one-cycle pulse: a channel finished draining.
REQ-015 SHALL have port done_wid  output  ID_W  tag of the channel finishing, valid with flush_done.
REQ-016 SHALL have port stall  input  1  freezes the drain side.
REQ-017 SHALL have port out_valid / out_ready / out_data / out_wid  output/input/output/output  1/1/WIDTH/ID_W  downstream beat handshake.
REQ-018 SHALL have port chan_busy  output  NUM_CH  per-channel allocated flag.

Function
REQ-019 Each channel SHALL hold tag, allocated, flushing, occupancy count (0..DEPTH) and a DEPTH-entry circular buffer with wrapping pointers.
REQ-020 A beat SHALL be routed to the allocated channel whose tag equals in_wid; if none, the lowest-index free channel SHALL be allocated with tag=in_wid on acceptance.
REQ-021 in_ready SHALL be 1 iff (matching channel exists, is not flushing, count<DEPTH) or (no match and a free channel exists); a match on a flushing channel SHALL deassert in_ready.
REQ-022 flush on an allocated non-flushing channel SHALL set its flushing flag next cycle; flush on a flushing channel SHALL be ignored; flush with no match SHALL pulse flush_err next cycle.
REQ-023 A push and a flush to the same WID in the same cycle SHALL both take effect: beat stored, then channel flushing.
REQ-024 Drain FSM SHALL have states IDLE, DRAIN, DONE.
REQ-025 IDLE: if any channel is flushing, select one round-robin starting after the last-served index, go to DRAIN next cycle.
REQ-026 DRAIN: out_valid = (selected count>0) & !stall; out_data/out_wid from selected channel head; pop on out_valid&out_ready; when count=0, go to DONE.
REQ-027 DONE: pulse flush_done with done_wid=tag, clear allocated/flushing for that channel, return to IDLE; total 2 cycles overhead per burst.
REQ-028 Only one channel SHALL drain at a time; beats of one WID SHALL leave contiguous and in arrival order.
REQ-029 A channel flushed with count=0 SHALL pass DRAIN with no beats and still pulse flush_done.
REQ-030 Push to a channel being drained is impossible (REQ-021); a channel freed in DONE SHALL be allocatable in the following cycle.

Reset
REQ-031 On rst all channels SHALL be freed, counts/pointers 0, FSM IDLE, round-robin pointer 0, immediately and irrespective of clk.
REQ-032 During and after reset in_ready=1, out_valid=0, flush_done=0, flush_err=0, done_wid=0, out_data=0, out_wid=0, chan_busy=0; buffered data is discarded mid-operation.

Configuration
REQ-033 With WBUF_LAST_GEN_EN defined, output port out_last (1 bit) SHALL exist and be 1 on the beat making the selected count reach 0; without it the port and logic SHALL be absent.

Verification
REQ-034 Push 3 beats wid=5, flush wid=5 -> 3 beats out in order with out_wid=5, flush_done with done_wid=5 exactly one cycle after final handshake in DONE.
REQ-035 Interleave beats wid 1,2,1,2 (NUM_CH=4), flush 2 then 1 -> all wid-2 beats contiguous before wid-1 beats.
REQ-036 Allocate NUM_CH distinct WIDs, present a new wid=9 -> in_ready=0 until a flush_done frees a channel.
REQ-037 Fill channel to DEPTH=16 -> in_ready=0 for that WID; flush with stall=1 -> out_valid=0 until stall=0.
REQ-038 flush wid=7 with no channel -> flush_err pulse, no state change; assert rst mid-drain -> all outputs reset values same cycle.

Source files
------------

// File: rtl/wbuf_multi_fifo.sv
// wbuf_multi_fifo: write buffer with NUM_CH WID-tagged channels, each a circular FIFO.
// Beats are steered into the channel that owns their WID. A flush marks a channel
// for draining, and the drain FSM empties one flushing channel at a time,
// picking channels round-robin.
// Optional feature: define WBUF_LAST_GEN_EN to add the out_last port.
module wbuf_multi_fifo #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned ID_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [ID_W-1:0]   in_wid,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [ID_W-1:0]   flush_wid,
    output logic              flush_err,
    output logic              flush_done,
    output logic [ID_W-1:0]   done_wid,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ID_W-1:0]   out_wid,
`ifdef WBUF_LAST_GEN_EN
    output logic              out_last,
`endif
    output logic [NUM_CH-1:0] chan_busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q;
    logic [CH_W-1:0]       sel_q;
    logic [CH_W-1:0]       rr_q;

    logic [ID_W-1:0]       tag_q   [NUM_CH];
    logic [NUM_CH-1:0]     alloc_q;
    logic [NUM_CH-1:0]     flushing_q;
    logic [CNT_W-1:0]      cnt_q   [NUM_CH];
    logic [PTR_W-1:0]      wr_q    [NUM_CH];
    logic [PTR_W-1:0]      rd_q    [NUM_CH];
    logic [WIDTH-1:0]      mem     [NUM_CH][DEPTH];

    logic                  in_hit;
    logic [CH_W-1:0]       in_idx;
    logic                  free_any;
    logic [CH_W-1:0]       free_idx;
    logic                  fl_hit;
    logic [CH_W-1:0]       fl_idx;
    logic                  fl_ok;
    logic [CH_W-1:0]       fl_tgt;
    logic                  fl_set;
    logic                  push;
    logic [CH_W-1:0]       push_idx;
    logic                  pop;
    logic                  pick_any;
    logic [CH_W-1:0]       pick_idx;
    logic                  sel_nonempty;
    logic                  drain_end;
    int                    pick_j;

    // Tag lookup for the incoming beat and the flush request, plus lowest free channel
    always_comb begin
        in_hit   = 1'b0;
        in_idx   = '0;
        free_any = 1'b0;
        free_idx = '0;
        fl_hit   = 1'b0;
        fl_idx   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (alloc_q[i] && (tag_q[i] == in_wid)) begin
                in_hit = 1'b1;
                in_idx = CH_W'(i);
            end
            if (!alloc_q[i]) begin
                free_any = 1'b1;
                free_idx = CH_W'(i);
            end
            if (alloc_q[i] && (tag_q[i] == flush_wid)) begin
                fl_hit = 1'b1;
                fl_idx = CH_W'(i);
            end
        end
    end

    // Accept decision, push target and flush target (a flush may name a channel allocated this cycle)
    always_comb begin
        in_ready = in_hit ? (!flushing_q[in_idx] && (cnt_q[in_idx] != CNT_W'(DEPTH)))
                          : free_any;
        push     = in_valid && in_ready;
        push_idx = in_hit ? in_idx : free_idx;
        fl_ok    = fl_hit;
        fl_tgt   = fl_idx;
        if (!fl_hit && push && !in_hit && (in_wid == flush_wid)) begin
            fl_ok  = 1'b1;
            fl_tgt = free_idx;
        end
        fl_set   = flush && fl_ok && !flushing_q[fl_tgt];
    end

    // Round-robin pick among flushing channels, starting after the last served one
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        pick_j   = 0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            pick_j = (int'(rr_q) + 1 + k) % int'(NUM_CH);
            if (flushing_q[CH_W'(pick_j)]) begin
                pick_any = 1'b1;
                pick_idx = CH_W'(pick_j);
            end
        end
    end

    // Drain-side handshake presented from the selected channel head
    always_comb begin
        sel_nonempty = (cnt_q[sel_q] != '0);
        out_valid    = (state_q == ST_DRAIN) && sel_nonempty && !stall;
        out_data     = out_valid ? mem[sel_q][rd_q[sel_q]] : '0;
        out_wid      = out_valid ? tag_q[sel_q] : '0;
        pop          = out_valid && out_ready;
        drain_end    = !sel_nonempty || (pop && (cnt_q[sel_q] == CNT_W'(1)));
        chan_busy    = alloc_q;
    end

`ifdef WBUF_LAST_GEN_EN
    // Marks the beat that empties the selected channel
    always_comb begin
        out_last = out_valid && (cnt_q[sel_q] == CNT_W'(1));
    end
`endif

    // Channel bookkeeping: allocation, counts, pointers, flushing flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_q    <= '0;
            flushing_q <= '0;
            flush_err  <= 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= '0;
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
            end
        end else begin
            flush_err <= flush && !fl_ok;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (push && (push_idx == CH_W'(i))) begin
                    wr_q[i] <= wr_q[i] + PTR_W'(1);
                    if (!in_hit) begin
                        alloc_q[i] <= 1'b1;
                        tag_q[i]   <= in_wid;
                    end
                end
                if (pop && (sel_q == CH_W'(i))) begin
                    rd_q[i] <= rd_q[i] + PTR_W'(1);
                end
                cnt_q[i] <= cnt_q[i]
                          + CNT_W'(push && (push_idx == CH_W'(i)))
                          - CNT_W'(pop && (sel_q == CH_W'(i)));
                if (fl_set && (fl_tgt == CH_W'(i))) begin
                    flushing_q[i] <= 1'b1;
                end
                if ((state_q == ST_DONE) && (sel_q == CH_W'(i))) begin
                    alloc_q[i]    <= 1'b0;
                    flushing_q[i] <= 1'b0;
                end
            end
        end
    end

    // Beat storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[push_idx][wr_q[push_idx]] <= in_data;
        end
    end

    // Drain FSM: select a flushing channel, empty it, then report completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_q       <= '0;
            flush_done <= 1'b0;
            done_wid   <= '0;
        end else begin
            flush_done <= 1'b0;
            done_wid   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel_q   <= pick_idx;
                        rr_q    <= pick_idx;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end) begin
                        state_q    <= ST_DONE;
                        flush_done <= 1'b1;
                        done_wid   <= tag_q[sel_q];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbuf_multi_fifo.sv
// Bench for wbuf_multi_fifo: a queue-based reference model is compared against the DUT
// every cycle, plus directed scenarios with literal expectations.
module tb_wbuf_multi_fifo;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned ID_W   = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  in_data = '0;
    logic [ID_W-1:0]   in_wid = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic [ID_W-1:0]   flush_wid = '0;
    logic              flush_err;
    logic              flush_done;
    logic [ID_W-1:0]   done_wid;
    logic              stall = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  out_data;
    logic [ID_W-1:0]   out_wid;
    logic [NUM_CH-1:0] chan_busy;

    wbuf_multi_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_wid(in_wid), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .flush_wid(flush_wid), .flush_err(flush_err),
        .flush_done(flush_done), .done_wid(done_wid), .stall(stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_wid(out_wid),
        .chan_busy(chan_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per-channel queues and drain phase (0 idle, 1 drain, 2 done)
    bit               m_alloc [NUM_CH];
    bit               m_fl    [NUM_CH];
    logic [ID_W-1:0]  m_tag   [NUM_CH];
    logic [WIDTH-1:0] m_q     [NUM_CH][$];
    int               m_phase;
    int               m_sel;
    int               m_rr;
    bit               m_ferr;
    bit               m_fdone;
    logic [ID_W-1:0]  m_dwid;

    // Observed handshakes and completions, for the directed checks
    logic [WIDTH-1:0] hs_data[$];
    logic [ID_W-1:0]  hs_wid[$];
    int               hs_cyc[$];
    logic [ID_W-1:0]  dn_wid[$];
    int               dn_cyc[$];

    function automatic void model_reset();
        for (int i = 0; i < int'(NUM_CH); i++) begin
            m_alloc[i] = 1'b0;
            m_fl[i]    = 1'b0;
            m_tag[i]   = '0;
            m_q[i].delete();
        end
        m_phase = 0; m_sel = 0; m_rr = 0;
        m_ferr = 1'b0; m_fdone = 1'b0; m_dwid = '0;
    endfunction

    // Compare on the falling edge, then advance the model across the next rising edge
    always @(negedge clk) begin
        int hit, free_i, pidx, fidx, j;
        bit e_ready, e_ov, push, pop, n_ferr, fset, n_fdone;
        logic [WIDTH-1:0] e_od;
        logic [ID_W-1:0] e_ow, n_dwid;
        logic [NUM_CH-1:0] e_busy;
        cyc++;
        if (rst) model_reset();
        hit = -1; free_i = -1;
        for (int i = 0; i < int'(NUM_CH); i++)
            if (m_alloc[i] && m_tag[i] == in_wid) hit = i;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--)
            if (!m_alloc[i]) free_i = i;
        e_ready = (hit >= 0) ? (!m_fl[hit] && m_q[hit].size() < int'(DEPTH)) : (free_i >= 0);
        e_ov    = (m_phase == 1) && (m_q[m_sel].size() > 0) && !stall;
        e_od    = e_ov ? m_q[m_sel][0] : '0;
        e_ow    = e_ov ? m_tag[m_sel] : '0;
        for (int i = 0; i < int'(NUM_CH); i++) e_busy[i] = m_alloc[i];

        check("in_ready", in_ready, e_ready);
        check("out_valid", out_valid, e_ov);
        check("out_data", out_data, e_od);
        check("out_wid", out_wid, e_ow);
        check("chan_busy", chan_busy, e_busy);
        check("flush_err", flush_err, m_ferr);
        check("flush_done", flush_done, m_fdone);
        check("done_wid", done_wid, m_dwid);

        if (!rst) begin
            if (out_valid && out_ready) begin
                hs_data.push_back(out_data); hs_wid.push_back(out_wid); hs_cyc.push_back(cyc);
            end
            if (flush_done) begin
                dn_wid.push_back(done_wid); dn_cyc.push_back(cyc);
            end
            push = in_valid && e_ready;
            pidx = (hit >= 0) ? hit : free_i;
            pop  = e_ov && out_ready;
            fidx = -1;
            for (int i = 0; i < int'(NUM_CH); i++)
                if (m_alloc[i] && m_tag[i] == flush_wid) fidx = i;
            if (fidx < 0 && push && hit < 0 && in_wid == flush_wid) fidx = pidx;
            n_ferr  = flush && (fidx < 0);
            fset    = flush && (fidx >= 0) && !m_fl[fidx];
            n_fdone = 1'b0;
            n_dwid  = '0;
            case (m_phase)
                0: begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        j = (m_rr + 1 + k) % int'(NUM_CH);
                        if (m_phase == 0 && m_fl[j]) begin
                            m_sel = j; m_rr = j; m_phase = 1;
                        end
                    end
                end
                1: begin
                    if (m_q[m_sel].size() - (pop ? 1 : 0) == 0) begin
                        m_phase = 2; n_fdone = 1'b1; n_dwid = m_tag[m_sel];
                    end
                end
                default: begin
                    m_alloc[m_sel] = 1'b0; m_fl[m_sel] = 1'b0; m_phase = 0;
                end
            endcase
            if (pop) void'(m_q[m_sel].pop_front());
            if (push) begin
                if (hit < 0) begin m_alloc[pidx] = 1'b1; m_tag[pidx] = in_wid; end
                m_q[pidx].push_back(in_data);
            end
            if (fset) m_fl[fidx] = 1'b1;
            m_ferr = n_ferr; m_fdone = n_fdone; m_dwid = n_dwid;
        end
    end

    // Advance to just after a rising edge and drop single-cycle requests
    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic clear_logs();
        hs_data.delete(); hs_wid.delete(); hs_cyc.delete();
        dn_wid.delete(); dn_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        // Reset values
        model_reset();
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_chan_busy", chan_busy, 0);
        repeat (2) tick();
        rst = 1'b0;

        // Three beats on wid 5, then flush
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'd5; in_data = 64'(100 + i);
        end
        tick(); flush = 1'b1; flush_wid = 11'd5;
        repeat (10) tick();
        check("t1_beats", hs_data.size(), 3);
        check("t1_dones", dn_wid.size(), 1);
        if (hs_data.size() == 3 && dn_wid.size() == 1) begin
            check("t1_d0", hs_data[0], 100);
            check("t1_d1", hs_data[1], 101);
            check("t1_d2", hs_data[2], 102);
            check("t1_w2", hs_wid[2], 5);
            check("t1_done_wid", dn_wid[0], 5);
            check("t1_done_gap", dn_cyc[0] - hs_cyc[2], 1);
        end

        // Interleaved wid 1/2, flush 2 then 1
        clear_logs();
        tick(); in_valid = 1'b1; in_wid = 11'd1; in_data = 64'hA1;
        tick(); in_valid = 1'b1; in_wid = 11'd2; in_data = 64'hB1;
        tick(); in_valid = 1'b1; in_wid = 11'd1; in_data = 64'hA2;
        tick(); in_valid = 1'b1; in_wid = 11'd2; in_data = 64'hB2;
        tick(); flush = 1'b1; flush_wid = 11'd2;
        tick(); flush = 1'b1; flush_wid = 11'd1;
        repeat (15) tick();
        check("t2_beats", hs_data.size(), 4);
        if (hs_data.size() == 4) begin
            check("t2_w0", hs_wid[0], 2);
            check("t2_w1", hs_wid[1], 2);
            check("t2_w2", hs_wid[2], 1);
            check("t2_d1", hs_data[1], 64'hB2);
            check("t2_d3", hs_data[3], 64'hA2);
        end

        // All channels taken, new wid 9 waits for a channel to free
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'(10 + i); in_data = 64'(i);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'd9; in_data = 64'h99;
            #1; check("t3_blocked", in_ready, 0);
        end
        tick(); in_valid = 1'b1; in_wid = 11'd9; flush = 1'b1; flush_wid = 11'd11;
        got = 0;
        for (int i = 0; i < 20 && got == 0; i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'd9; in_data = 64'h99;
            #1; if (in_ready) got = 1;
        end
        check("t3_freed", got, 1);
        check("t3_done_first", dn_wid.size(), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); flush = 1'b1;
            flush_wid = (i == 1) ? 11'd9 : 11'(10 + i);
        end
        repeat (40) tick();
        check("t3_all_free", chan_busy, 0);

        // Full channel blocks its wid; stall holds drain off
        clear_logs();
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'd20; in_data = 64'(i);
        end
        tick(); in_valid = 1'b1; in_wid = 11'd20;
        #1; check("t4_full", in_ready, 0);
        tick(); stall = 1'b1; flush = 1'b1; flush_wid = 11'd20;
        for (int i = 0; i < 5; i++) begin
            tick(); #1; check("t4_stalled", out_valid, 0);
        end
        tick(); stall = 1'b0;
        repeat (30) tick();
        check("t4_beats", hs_data.size(), DEPTH);
        check("t4_dones", dn_wid.size(), 1);

        // Flush of an unknown wid, then reset during a drain
        tick(); flush = 1'b1; flush_wid = 11'd7;
        tick();
        check("t5_ferr", flush_err, 1);
        check("t5_busy", chan_busy, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); in_valid = 1'b1; in_wid = 11'd30; in_data = 64'(50 + i);
        end
        tick(); flush = 1'b1; flush_wid = 11'd30;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick(); if (out_valid) got = 1;
        end
        check("t5_draining", got, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_ov", out_valid, 0);
        check("t5_rst_od", out_data, 0);
        check("t5_rst_ow", out_wid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_busy", chan_busy, 0);
        check("t5_rst_fd", flush_done, 0);
        repeat (2) tick();
        rst = 1'b0;

        // Randomised traffic with more WIDs than channels
        for (int n = 0; n < 3000; n++) begin
            tick();
            in_valid  = 1'($urandom_range(0, 1));
            in_wid    = 11'($urandom_range(1, 6));
            in_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 9) == 0);
            flush_wid = 11'($urandom_range(1, 7));
            stall     = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 999) == 0);
        end
        tick();
        rst = 1'b0; stall = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
